// File: rtl/key_conditioner_pkg.sv
// Board-level constants and shared types for the key conditioner.
// Contents:
//   CLK_FREQ_HZ           board clock frequency everything is derived from
//   KEYS_W                number of board push-buttons
//   DEBOUNCE_CYCLES_DEF   10 ms of clk_i
//   REPEAT_DELAY_DEF      300 ms hold before first auto-repeat
//   REPEAT_PERIOD_DEF     50 ms between auto-repeats
//   rep_state_e           per-key auto-repeat FSM states
//   max2()                elaboration-time helper for counter sizing
package key_conditioner_pkg;

    localparam int CLK_FREQ_HZ         = 50_000_000;
    localparam int KEYS_W              = 4;
    localparam int DEBOUNCE_CYCLES_DEF = CLK_FREQ_HZ / 100;
    localparam int REPEAT_DELAY_DEF    = (CLK_FREQ_HZ / 10) * 3;
    localparam int REPEAT_PERIOD_DEF   = CLK_FREQ_HZ / 20;

    typedef enum logic [1:0] {
        REP_IDLE   = 2'd0,
        REP_DELAY  = 2'd1,
        REP_REPEAT = 2'd2,
        REP_HOLD   = 2'd3
    } rep_state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key conditioner: two-flop synchronizer, polarity normalisation,
// debouncer, press/release pulses and auto-repeat pulse stream.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   raw            raw asynchronous button pin
//   level          debounced level, 1 = held
//   press, rel     one-cycle pulses aligned with the first cycle of a new level
//   rpt            pulse on press, then auto-repeat pulses while held
module key_debounce
    import key_conditioner_pkg::*;
#(
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel,
    output logic rpt
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be >= 1");
    end
    if (REPEAT_PERIOD < 1) begin : g_bad_period
        $error("REPEAT_PERIOD must be >= 1");
    end

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int RC_W = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD)) + 1;
    localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RC_W-1:0] DELAY_LAST  = RC_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [RC_W-1:0] PERIOD_LAST = RC_W'(REPEAT_PERIOD - 1);
    // Sync flops come out of reset at the released pin level so no phantom press.
    localparam logic IDLE_LVL = ACTIVE_LOW;

    logic [1:0]      sync;
    logic            s;
    logic [DB_W-1:0] db_cnt;
    logic            toggle, press_evt, rel_evt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync <= {2{IDLE_LVL}};
        else         sync <= {sync[0], raw};
    end

    assign s = ACTIVE_LOW ? ~sync[1] : sync[1];

    assign toggle    = (s != level) && (db_cnt == DB_LAST);
    assign press_evt = toggle & ~level;
    assign rel_evt   = toggle & level;

    // Any cycle of agreement clears the count, so a glitch restarts debounce.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level  <= 1'b0;
            db_cnt <= '0;
            press  <= 1'b0;
            rel    <= 1'b0;
        end else begin
            press <= press_evt;
            rel   <= rel_evt;
            if (s == level || toggle) db_cnt <= '0;
            else                      db_cnt <= db_cnt + 1'b1;
            if (toggle) level <= ~level;
        end
    end

    // Auto-repeat FSM
    rep_state_e      state, state_nxt;
    logic [RC_W-1:0] rcnt, rcnt_nxt;
    logic            fire;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= REP_IDLE;
            rcnt  <= '0;
            rpt   <= 1'b0;
        end else begin
            state <= state_nxt;
            rcnt  <= rcnt_nxt;
            rpt   <= fire;
        end
    end

    always_comb begin
        state_nxt = state;
        if (rel_evt) begin
            state_nxt = REP_IDLE;
        end else begin
            case (state)
                REP_IDLE:  if (press_evt) state_nxt = (REPEAT_DELAY == 0) ? REP_HOLD : REP_DELAY;
                REP_DELAY: if (rcnt == DELAY_LAST) state_nxt = REP_REPEAT;
                default:   state_nxt = state;
            endcase
        end
    end

    // Release wins over a repeat due on the same edge.
    always_comb begin
        fire     = 1'b0;
        rcnt_nxt = rcnt + 1'b1;
        if (rel_evt) begin
            rcnt_nxt = '0;
        end else begin
            case (state)
                REP_IDLE: begin
                    fire     = press_evt;
                    rcnt_nxt = '0;
                end
                REP_DELAY: if (rcnt == DELAY_LAST) begin
                    fire     = 1'b1;
                    rcnt_nxt = '0;
                end
                REP_REPEAT: if (rcnt == PERIOD_LAST) begin
                    fire     = 1'b1;
                    rcnt_nxt = '0;
                end
                default: rcnt_nxt = '0;
            endcase
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Conditions raw board push-buttons for the game logic: one independent
// key_debounce per key, outputs all active-high.
// Ports:
//   clk_i       system clock (game_logic clock)
//   rst_ni      asynchronous reset, active-low
//   keys_raw_i  raw asynchronous button pins
//   keys_o      debounced level, 1 = held
//   press_o     one-cycle pulse when keys_o rises
//   release_o   one-cycle pulse when keys_o falls
//   repeat_o    pulse on press, then auto-repeat pulses while held
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int N_KEYS          = KEYS_W,
    parameter bit KEYS_ACTIVE_LOW = 1'b1,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [N_KEYS-1:0] keys_raw_i,
    output logic [N_KEYS-1:0] keys_o,
    output logic [N_KEYS-1:0] press_o,
    output logic [N_KEYS-1:0] release_o,
    output logic [N_KEYS-1:0] repeat_o
);

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        key_debounce #(
            .ACTIVE_LOW      (KEYS_ACTIVE_LOW),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_key (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .raw    (keys_raw_i[k]),
            .level  (keys_o[k]),
            .press  (press_o[k]),
            .rel    (release_o[k]),
            .rpt    (repeat_o[k])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] raw;
    logic [1:0] keys, press, rel, rpt;
    int         total = 0;
    int         bad = 0;

    key_conditioner #(
        .N_KEYS          (2),
        .KEYS_ACTIVE_LOW (1'b1),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .keys_raw_i (raw),
        .keys_o     (keys),
        .press_o    (press),
        .release_o  (rel),
        .repeat_o   (rpt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // keys/press/rel/rpt packed as {keys,press,rel,rpt}
    task automatic test_reset();
        logic [7:0] exp;
        rst_n = 1'b0;
        raw   = 2'b11;
        exp   = 8'h00;
        for (int i = 0; i < 20; i++) begin
            step();
            total++;
            if ({keys, press, rel, rpt} !== exp) begin
                bad++;
                $display("FAIL reset cyc=%0d got=%b want=%b", i, {keys, press, rel, rpt}, exp);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if ({keys, press, rel, rpt} !== exp) begin
                bad++;
                $display("FAIL post_reset_idle cyc=%0d got=%b want=%b", i, {keys, press, rel, rpt}, exp);
            end
        end
    endtask

    task automatic test_press();
        logic [7:0] exp;
        raw[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            exp = {1'b0, i >= 5, 1'b0, i == 5, 2'b00, 1'b0, i == 5};
            total++;
            if ({keys, press, rel, rpt} !== exp) begin
                bad++;
                $display("FAIL press0 edge=E0+%0d got=%b want=%b", i, {keys, press, rel, rpt}, exp);
            end
        end
    endtask

    // Release lands exactly where the first delayed repeat would fire.
    task automatic test_release_vs_repeat();
        logic [7:0] exp;
        raw[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            exp = {1'b0, i < 5, 2'b00, 1'b0, i == 5, 2'b00};
            total++;
            if ({keys, press, rel, rpt} !== exp) begin
                bad++;
                $display("FAIL release0 edge=%0d got=%b want=%b", i, {keys, press, rel, rpt}, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [7:0] exp;
        exp = 8'h00;
        raw[0] = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (i == 3) raw[0] = 1'b1;
            step();
            total++;
            if ({keys, press, rel, rpt} !== exp) begin
                bad++;
                $display("FAIL glitch edge=%0d got=%b want=%b", i, {keys, press, rel, rpt}, exp);
            end
        end
    endtask

    task automatic test_bounce();
        logic [7:0] exp;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) raw[0] = 1'b0;
            if (i == 1) raw[0] = 1'b1;
            if (i == 2) raw[0] = 1'b0;
            step();
            exp = {1'b0, i >= 7, 1'b0, i == 7, 2'b00, 1'b0, i == 7};
            total++;
            if ({keys, press, rel, rpt} !== exp) begin
                bad++;
                $display("FAIL bounce edge=%0d got=%b want=%b", i, {keys, press, rel, rpt}, exp);
            end
        end
        raw[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            exp = {1'b0, i < 5, 2'b00, 1'b0, i == 5, 2'b00};
            total++;
            if ({keys, press, rel, rpt} !== exp) begin
                bad++;
                $display("FAIL bounce_release edge=%0d got=%b want=%b", i, {keys, press, rel, rpt}, exp);
            end
        end
    endtask

    // Press at P = edge 5; release edge P+40 coincides with a due repeat.
    task automatic test_repeat();
        logic [7:0] exp;
        logic       r;
        raw[1] = 1'b0;
        for (int i = 0; i < 51; i++) begin
            if (i == 40) raw[1] = 1'b1;
            step();
            r   = (i == 5) || (i >= 15 && i <= 42 && ((i - 15) % 3) == 0);
            exp = {i >= 5 && i < 45, 1'b0, i == 5, 1'b0, i == 45, 1'b0, r, 1'b0};
            total++;
            if ({keys, press, rel, rpt} !== exp) begin
                bad++;
                $display("FAIL repeat1 edge=P+%0d got=%b want=%b", i - 5, {keys, press, rel, rpt}, exp);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        logic [7:0] exp;
        raw[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            exp = {1'b0, i >= 5, 1'b0, i == 5, 2'b00, 1'b0, i == 5};
            total++;
            if ({keys, press, rel, rpt} !== exp) begin
                bad++;
                $display("FAIL hold_before_reset edge=%0d got=%b want=%b", i, {keys, press, rel, rpt}, exp);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({keys, press, rel, rpt} !== 8'h00) begin
            bad++;
            $display("FAIL async_reset got=%b want=%b", {keys, press, rel, rpt}, 8'h00);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({keys, press, rel, rpt} !== 8'h00) begin
                bad++;
                $display("FAIL in_reset cyc=%0d got=%b want=%b", i, {keys, press, rel, rpt}, 8'h00);
            end
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            exp = {1'b0, i >= 6, 1'b0, i == 6, 2'b00, 1'b0, i == 6};
            total++;
            if ({keys, press, rel, rpt} !== exp) begin
                bad++;
                $display("FAIL rerise edge=D%0d got=%b want=%b", i, {keys, press, rel, rpt}, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_release_vs_repeat();
        test_glitch();
        test_bounce();
        test_repeat();
        test_reset_mid_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
